// File: rtl/seg_disp_pkg.sv
// Shared constants and types for the 7-segment display arbiter.
package seg_disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    // Pick one digit's 7-bit pattern out of a packed 4-digit bundle.
    function automatic logic [SEG_W-1:0] digit_slice(
        input logic [NUM_DIGITS*SEG_W-1:0] segs,
        input logic [1:0]                  digit
    );
        logic [SEG_W-1:0] s;
        case (digit)
            2'd0:    s = segs[6:0];
            2'd1:    s = segs[13:7];
            2'd2:    s = segs[20:14];
            default: s = segs[27:21];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot prescaler and digit counter; flags the last cycle of each 4-digit frame.
module seg_scan_timer
    import seg_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    output logic [1:0] digit,
    output logic       frame_end
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [1:0]    digit_q;
    logic          slot_end;

    assign slot_end  = (presc_q == PRESC_LAST);
    assign frame_end = slot_end && (digit_q == 2'(NUM_DIGITS - 1));
    assign digit     = digit_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            presc_q <= '0;
            digit_q <= '0;
        end else if (slot_end) begin
            presc_q <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates the shared 4-digit display between requesters A and B (B has priority)
// and scans the current owner's patterns onto seg/an.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV     = 100_000,
    parameter int unsigned MIN_HOLD_FRAMES = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [27:0] segs_a,
    input  logic [27:0] segs_b,
    output logic        grant_a,
    output logic        grant_b,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned HW = $clog2(MIN_HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD_FRAMES);

    logic [1:0]       digit;
    logic             frame_end;
    arb_state_t       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             tick_q;

    seg_scan_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .digit    (digit),
        .frame_end(frame_end)
    );

    always_comb begin
        state_d = state_q;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (req_b)      state_d = OWN_B;
                    else if (req_a) state_d = OWN_A;
                end
                OWN_A: begin
                    if (!req_a)                  state_d = req_b ? OWN_B : IDLE;
                    else if (req_b && hold_q >= HOLD_MAX) state_d = OWN_B;
                end
                OWN_B: begin
                    if (!req_b) state_d = req_a ? OWN_A : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // hold counts frames completed under the current owner, saturating
    always_comb begin
        hold_d = hold_q;
        if (state_d != state_q)                hold_d = '0;
        else if (frame_end && hold_q < HOLD_MAX) hold_d = hold_q + HW'(1);
    end

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        unique case (state_q)
            OWN_A: begin
                seg_d = digit_slice(segs_a, digit);
                an_d  = ~(4'b0001 << digit);
            end
            OWN_B: begin
                seg_d = digit_slice(segs_b, digit);
                an_d  = ~(4'b0001 << digit);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            hold_q  <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= frame_end;
        end
    end

    assign grant_a    = (state_q == OWN_A);
    assign grant_b    = (state_q == OWN_B);
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: a cycle model predicts each post-edge output set, DUT is compared at negedge.
module tb_seg_display_arbiter;

    localparam int unsigned DIV  = 4;
    localparam int unsigned HOLD = 2;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        req_a, req_b;
    logic [27:0] segs_a, segs_b;
    logic        grant_a, grant_b, frame_tick;
    logic [6:0]  seg;
    logic [3:0]  an;

    typedef struct packed {
        logic       ga;
        logic       gb;
        logic       tick;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // model state: 0 idle, 1 A owns, 2 B owns
    int m_state = 0;
    int m_hold  = 0;
    int m_pos   = 0;

    always #5 CLOCK = ~CLOCK;

    seg_display_arbiter #(
        .REFRESH_DIV    (DIV),
        .MIN_HOLD_FRAMES(HOLD)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .req_a     (req_a),
        .req_b     (req_b),
        .segs_a    (segs_a),
        .segs_b    (segs_b),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        exp_t e;
        int   d;
        int   ns;
        bit   fe;
        d  = (m_pos / DIV) % 4;
        fe = (m_pos == 4 * DIV - 1);
        if (RESET) begin
            e       = '{ga: 1'b0, gb: 1'b0, tick: 1'b0, an: 4'hF, seg: 7'h7F};
            m_state = 0;
            m_hold  = 0;
            m_pos   = 0;
        end else begin
            e.tick = fe;
            if (m_state == 0) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end else begin
                e.an  = 4'hF & ~(4'b1 << d);
                e.seg = 7'((((m_state == 1) ? segs_a : segs_b) >> (7 * d)) & 28'h7F);
            end
            if (fe) begin
                ns = m_state;
                case (m_state)
                    0: ns = req_b ? 2 : (req_a ? 1 : 0);
                    1: if (!req_a) ns = req_b ? 2 : 0;
                       else if (req_b && m_hold >= HOLD) ns = 2;
                    default: if (!req_b) ns = req_a ? 1 : 0;
                endcase
                if (ns != m_state) m_hold = 0;
                else if (m_hold < HOLD) m_hold++;
                m_state = ns;
            end
            m_pos = (m_pos + 1) % (4 * DIV);
            e.ga  = (m_state == 1);
            e.gb  = (m_state == 2);
        end
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge CLOCK);
        @(negedge CLOCK);
        cyc++;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("grant_a", 32'(grant_a), 32'(e.ga));
            check("grant_b", 32'(grant_b), 32'(e.gb));
            check("frame_tick", 32'(frame_tick), 32'(e.tick));
            check("an", 32'(an), 32'(e.an));
            check("seg", 32'(seg), 32'(e.seg));
            check("both_grants", 32'(grant_a & grant_b), 32'd0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < 4 * DIV && m_pos != p; i++) cycle();
    endtask

    task automatic wait_owner(input int who, input string tag);
        for (int i = 0; i < 64 && m_state != who; i++) cycle();
        check(tag, 32'(m_state), 32'(who));
    endtask

    initial begin
        RESET  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        segs_a = 28'h0123456;
        segs_b = 28'hABCDEF0;
        run(2);
        RESET = 1'b0;

        // 1: idle scanning, display blank, frame_tick every 16 cycles
        run(40);

        // 2: A requests mid-frame; granted at next frame_end
        req_a = 1'b1;
        wait_owner(1, "grant_a_wait");
        run(2 * 4 * DIV);

        // 3: freshly granted A, B requests; A kept until hold reaches minimum
        goto_pos(0);
        req_a = 1'b0;
        run(4 * DIV);
        req_a = 1'b1;
        wait_owner(1, "regrant_a");
        req_b = 1'b1;
        for (int i = 0; i < 4 * 4 * DIV; i++) begin
            segs_a = 28'($urandom);
            segs_b = 28'($urandom);
            cycle();
        end

        // 4: B holds against A for 10 frames, then hands back
        run(10 * 4 * DIV);
        goto_pos(6);
        req_b = 1'b0;
        run(2 * 4 * DIV);

        // 5: owner glitches its request within a frame
        goto_pos(5);
        req_a = 1'b0;
        run(3);
        req_a = 1'b1;
        run(3 * 4 * DIV);
        goto_pos(9);
        req_b = 1'b1;
        run(2);
        req_b = 1'b0;
        run(2 * 4 * DIV);

        // 6: reset mid-frame while B owns
        req_b = 1'b1;
        wait_owner(2, "grant_b_wait");
        goto_pos(7);
        RESET = 1'b1;
        run(1);
        RESET = 1'b0;
        run(3 * 4 * DIV);

        // idle with nothing requested after release
        req_a = 1'b0;
        req_b = 1'b0;
        run(2 * 4 * DIV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
